cvmcu_cpi_rx_packer: RTL and testbench
======================================

# cvmcu_cpi_rx_packer

Parametrised CORE-V-MCU Camera Parallel Interface receiver. It captures pixels qualified by `cam_vsync_i`/`cam_hsync_i`, optionally decimates them 2:1 or 4:1 in both axes, and packs them into 32-bit words. Words are buffered in a show-ahead FIFO and leave through a valid/ready stream toward the uDMA RX channel. Frame statistics and a sticky overflow flag are available to the register file.

## Interface
- `DATA_WIDTH`, 8, pixel width; legal values 8, 10, 12, 16.
- `FIFO_DEPTH`, 8, output FIFO entries; must be a power of 2 and ≥ 2.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `en_i`  in  1  capture enable; sampled only at a vsync rising edge.
- `decim_i`  in  2  decimation select: 0 = none, 1 = 2:1, 2 = 4:1, 3 = treated as 2; sampled at frame start.
- `clr_i`  in  1  clears `overflow_o`.
- `cam_data_i`  in  DATA_WIDTH  pixel data.
- `cam_hsync_i`  in  1  line-valid, high during active pixels.
- `cam_vsync_i`  in  1  frame-valid, high for the whole frame.
- `out_data_o`  out  32  packed word.
- `out_sof_o`  out  1  marks the first word of a frame; qualified by `out_valid_o`.
- `out_valid_o`  out  1  word available.
- `out_ready_i`  in  1  consumer accepts the word.
- `frame_done_o`  out  1  one-cycle pulse at the end of a captured frame.
- `lines_o`  out  16  line count of the last captured frame.
- `overflow_o`  out  1  sticky FIFO overflow flag.

## Operation
- **Input register:** `cam_*_i` are registered once. All edge detection and qualification use the registered copies. The previous-vsync register resets to 1, so a frame already in progress at reset release is skipped.
- **FSM states:** IDLE, CAPTURE, DROP.
  - IDLE → CAPTURE on a vsync rising edge with `en_i` = 1. This edge latches `decim_i`, zeroes the line/pixel indices and the line counter, and arms SOF.
  - CAPTURE → IDLE on a vsync falling edge.
  - CAPTURE → DROP on overflow.
  - DROP → IDLE on a vsync falling edge.
- **Pixel valid:** state is CAPTURE and registered vsync & hsync are both 1.
- **Indices:** the pixel index increments per valid pixel and clears on an hsync falling edge. The line index and line counter increment on each hsync falling edge. The line counter saturates at 0xFFFF.
- **Decimation:** mask = 0, 1 or 3. A pixel is kept when (pix_idx & mask) == 0 and (line_idx & mask) == 0.
- **Packing, lanes = 4 when DATA_WIDTH = 8:** pixel k goes to bits [8k+7:8k].
- **Packing, lanes = 2 otherwise:** pixel k goes to bits [16k+DATA_WIDTH-1:16k]; unused bits are 0.
- **Line boundaries:** the first pixel goes in lane 0. Packing continues across lines; lines do not flush.
- **Frame end (vsync falling edge in CAPTURE):**
  - A non-empty partial word is pushed, with empty lanes zero.
  - `lines_o` is updated.
  - `frame_done_o` pulses.
- **SOF:** `out_sof_o` is stored in the FIFO beside the first word pushed after frame start.
- **Overflow:** a push while the FIFO is full drops the word and sets `overflow_o`.
  - The FSM enters DROP. DROP discards the rest of the frame, does not pulse `frame_done_o` and does not update `lines_o`.
  - A flush push into a full FIFO behaves the same way: word dropped, overflow set, no `frame_done_o`.
- **`clr_i`:** clears `overflow_o`. When a new overflow occurs in the same cycle as `clr_i`, set wins.
- **`en_i`:** changes during a frame have no effect until the next frame start.
- **Reset values:**
  - Outputs: `out_valid_o` = 0, `out_sof_o` = 0, `out_data_o` = 0, `frame_done_o` = 0, `lines_o` = 0, `overflow_o` = 0.
  - Internal: FIFO empty, FSM in IDLE.
  - A reset mid-frame discards all buffered data.

## Timing
- **Latency:** the last pixel of a word is present on `cam_*_i` at edge E. `out_valid_o` rises after edge E+2 when the FIFO is empty: one cycle in the input register, one cycle in the pack/write stage.
- **Flush latency:** the vsync falling edge is present on `cam_vsync_i` at edge E.
  - The flushed word is written at edge E+2.
  - `frame_done_o` is high in the cycle after edge E+2, in the same cycle as the flushed word's `out_valid_o`.
  - `lines_o` takes its new value after edge E+2.
- **Handshake:** a transfer occurs when valid & ready are both 1. Data and SOF are stable while valid = 1 and ready = 0.
- **Full FIFO:** simultaneous push and pop on a full FIFO is legal and is not an overflow.
- **Throughput:** one pixel per clock; at most one FIFO push per clock.

## Structure
- Package `cvmcu_cpi_pkg`:
  - `cpi_state_e` enum.
  - `cpi_decim_e` enum.
  - constant `CPI_WORD_WIDTH` = 32.
  - function `cpi_lanes(DATA_WIDTH)`.
- Sub-module `cvmcu_cpi_fifo`: synchronous show-ahead FIFO, width 33 (data + SOF), depth `FIFO_DEPTH`.

## Test plan
- **8-bit packing, no decimation:** DATA_WIDTH = 8, 1 line of 8 pixels 0x01..0x08, ready held at 1.
  - Words 0x04030201 (SOF = 1) and 0x08070605.
  - `lines_o` = 1; one `frame_done_o` pulse.
- **16-bit flush:** DATA_WIDTH = 16, 3 pixels 0xAAAA, 0xBBBB, 0xCCCC, then vsync falls.
  - Words 0xBBBBAAAA and 0x0000CCCC.
- **4:1 decimation:** DATA_WIDTH = 8, decim = 2, 4 lines × 16 pixels with pixel value = column index.
  - Single word 0x0C080400 from line 0 only.
  - `lines_o` = 4.
- **Backpressure overflow:** FIFO_DEPTH = 4, ready = 0, 24 pixels.
  - `overflow_o` = 1 after the 5th word; no `frame_done_o`.
  - Next frame with ready = 1 captures normally.
  - `clr_i` clears the flag.
- **Reset mid-frame:** assert `rst_i` mid-line.
  - All outputs return to 0.
  - The vsync still high after reset is ignored.
  - The next vsync rising edge starts a frame with SOF.
- **`en_i` handling:** `en_i` = 0 at vsync rise produces no words. `en_i` dropped mid-frame still completes that frame.

Source files
------------

// File: rtl/cvmcu_cpi_pkg.sv
// Shared types and helpers for the CORE-V-MCU camera parallel interface receiver.
package cvmcu_cpi_pkg;

    localparam int CPI_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        CPI_IDLE    = 2'd0,
        CPI_CAPTURE = 2'd1,
        CPI_DROP    = 2'd2
    } cpi_state_e;

    typedef enum logic [1:0] {
        CPI_DECIM_NONE  = 2'd0,
        CPI_DECIM_2     = 2'd1,
        CPI_DECIM_4     = 2'd2,
        CPI_DECIM_4_ALT = 2'd3
    } cpi_decim_e;

    // 8-bit pixels pack four to a word, wider pixels two to a word in 16-bit lanes.
    function automatic int cpi_lanes(input int data_width);
        return (data_width == 8) ? 4 : 2;
    endfunction

    function automatic logic [1:0] cpi_decim_mask(input cpi_decim_e decim);
        case (decim)
            CPI_DECIM_NONE: return 2'b00;
            CPI_DECIM_2:    return 2'b01;
            default:        return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/cvmcu_cpi_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on pop_data whenever not empty.
module cvmcu_cpi_fifo
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cvmcu_cpi_rx_packer.sv
// Camera parallel interface receiver: registers the camera bus, decimates, packs pixels
// into 32-bit words and buffers them for a valid/ready consumer.
module cvmcu_cpi_rx_packer
    import cvmcu_cpi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [1:0]            decim_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] cam_data_i,
    input  logic                  cam_hsync_i,
    input  logic                  cam_vsync_i,
    output logic [31:0]           out_data_o,
    output logic                  out_sof_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  frame_done_o,
    output logic [15:0]           lines_o,
    output logic                  overflow_o
);

    localparam int         LANES     = cpi_lanes(DATA_WIDTH);
    localparam int         LANE_W    = CPI_WORD_WIDTH / LANES;
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  hsync_q, vsync_q, hsync_prev, vsync_prev;
    logic                  vsync_rise, vsync_fall, hsync_fall;

    cpi_state_e            state_q, state_d;
    logic                  capturing, frame_start, frame_end;

    cpi_decim_e            decim_q;
    logic [1:0]            mask;
    logic [1:0]            pix_idx, line_idx, lane;
    logic [15:0]           line_cnt, line_cnt_nxt, end_lines;
    logic [31:0]           pack_word, packed_word;
    logic                  sof_armed, pix_valid, keep;

    logic                  push_valid, push_sof, end_pending;
    logic [31:0]           push_data;
    logic                  push_req, ovf, fifo_full, fifo_empty;
    logic [32:0]           fifo_rdata;

    // vsync history resets high so a frame already running at reset release is not seen as a start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b1;
            hsync_prev <= 1'b0;
            vsync_prev <= 1'b1;
        end else begin
            data_q     <= cam_data_i;
            hsync_q    <= cam_hsync_i;
            vsync_q    <= cam_vsync_i;
            hsync_prev <= hsync_q;
            vsync_prev <= vsync_q;
        end
    end

    assign vsync_rise = vsync_q && !vsync_prev;
    assign vsync_fall = !vsync_q && vsync_prev;
    assign hsync_fall = !hsync_q && hsync_prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= CPI_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPI_IDLE:    if (vsync_rise && en_i) state_d = CPI_CAPTURE;
            CPI_CAPTURE: if (vsync_fall)         state_d = CPI_IDLE;
                         else if (ovf)           state_d = CPI_DROP;
            CPI_DROP:    if (vsync_fall)         state_d = CPI_IDLE;
            default:                             state_d = CPI_IDLE;
        endcase
    end

    // A frame whose last push overflowed in the same cycle as vsync falls is treated as dropped.
    always_comb begin
        capturing   = (state_q == CPI_CAPTURE);
        frame_start = (state_q == CPI_IDLE) && vsync_rise && en_i;
        frame_end   = capturing && vsync_fall && !ovf;
    end

    assign mask      = cpi_decim_mask(decim_q);
    assign pix_valid = capturing && vsync_q && hsync_q;
    assign keep      = pix_valid && ((pix_idx & mask) == 2'b00) && ((line_idx & mask) == 2'b00);

    always_comb begin
        packed_word = pack_word;
        packed_word[int'(lane) * LANE_W +: DATA_WIDTH] = data_q;
    end

    always_comb begin
        line_cnt_nxt = line_cnt;
        if (capturing && hsync_fall && line_cnt != 16'hFFFF) line_cnt_nxt = line_cnt + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            decim_q     <= CPI_DECIM_NONE;
            pix_idx     <= '0;
            line_idx    <= '0;
            line_cnt    <= '0;
            lane        <= '0;
            pack_word   <= '0;
            sof_armed   <= 1'b0;
            push_valid  <= 1'b0;
            push_data   <= '0;
            push_sof    <= 1'b0;
            end_pending <= 1'b0;
            end_lines   <= '0;
        end else begin
            push_valid  <= 1'b0;
            end_pending <= 1'b0;
            if (frame_start) begin
                decim_q   <= cpi_decim_e'(decim_i);
                pix_idx   <= '0;
                line_idx  <= '0;
                line_cnt  <= '0;
                lane      <= '0;
                pack_word <= '0;
                sof_armed <= 1'b1;
            end else if (capturing) begin
                line_cnt <= line_cnt_nxt;
                if (hsync_fall) begin
                    pix_idx  <= '0;
                    line_idx <= line_idx + 2'd1;
                end else if (pix_valid) begin
                    pix_idx  <= pix_idx + 2'd1;
                end
                if (keep) begin
                    if (lane == LAST_LANE) begin
                        push_valid <= 1'b1;
                        push_data  <= packed_word;
                        push_sof   <= sof_armed;
                        sof_armed  <= 1'b0;
                        lane       <= '0;
                        pack_word  <= '0;
                    end else begin
                        lane       <= lane + 2'd1;
                        pack_word  <= packed_word;
                    end
                end else if (frame_end) begin
                    push_valid  <= (lane != 2'd0);
                    push_data   <= pack_word;
                    push_sof    <= sof_armed;
                    end_pending <= 1'b1;
                    end_lines   <= line_cnt_nxt;
                    lane        <= '0;
                    pack_word   <= '0;
                    if (lane != 2'd0) sof_armed <= 1'b0;
                end
            end
        end
    end

    // A full FIFO that is popping this cycle still accepts the push.
    assign push_req = push_valid && (state_q != CPI_DROP);
    assign ovf      = push_req && fifo_full && !out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_done_o <= 1'b0;
            lines_o      <= '0;
            overflow_o   <= 1'b0;
        end else begin
            frame_done_o <= end_pending && !ovf;
            if (end_pending && !ovf) lines_o <= end_lines;
            if (ovf)        overflow_o <= 1'b1;
            else if (clr_i) overflow_o <= 1'b0;
        end
    end

    cvmcu_cpi_fifo #(
        .WIDTH (CPI_WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_req && !ovf),
        .push_data ({push_sof, push_data}),
        .pop       (out_ready_i),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_empty ? 32'd0 : fifo_rdata[31:0];
    assign out_sof_o   = !fifo_empty && fifo_rdata[32];

endmodule

// File: tb/tb_cvmcu_cpi_rx_packer.sv
// Scoreboard bench: an 8-bit and a 16-bit receiver share one camera bus; a frame-level model
// predicts each word stream and frame-done pulse, and a negedge monitor compares them.
module tb_cvmcu_cpi_rx_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [1:0]  decim = 2'd0;
    logic        clr = 1'b0;
    logic [15:0] cam_data = '0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        ready = 1'b0;
    int          ready_mode = 0;

    logic [31:0] data8, data16;
    logic        sof8, sof16, valid8, valid16, done8, done16, ovf8, ovf16;
    logic [15:0] lines8, lines16;

    int          checks = 0;
    int          failures = 0;

    int          fr_line[$];
    int          fr_col[$];
    logic [15:0] fr_val[$];
    int          line_len[$];
    int          fr_lines;

    logic [32:0] exp8[$];
    logic [32:0] exp16[$];
    int          exp_done8[$];
    int          exp_done16[$];
    int          last_lines8 = 0;
    int          last_lines16 = 0;
    logic [32:0] e8, e16;
    int          d8, d16;

    cvmcu_cpi_rx_packer #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut8 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .decim_i(decim), .clr_i(clr),
        .cam_data_i(cam_data[7:0]), .cam_hsync_i(hsync), .cam_vsync_i(vsync),
        .out_data_o(data8), .out_sof_o(sof8), .out_valid_o(valid8), .out_ready_i(ready),
        .frame_done_o(done8), .lines_o(lines8), .overflow_o(ovf8)
    );

    cvmcu_cpi_rx_packer #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut16 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .decim_i(decim), .clr_i(clr),
        .cam_data_i(cam_data), .cam_hsync_i(hsync), .cam_vsync_i(vsync),
        .out_data_o(data16), .out_sof_o(sof16), .out_valid_o(valid16), .out_ready_i(ready),
        .frame_done_o(done16), .lines_o(lines16), .overflow_o(ovf16)
    );

    always #5 clk = ~clk;

    // Random mode never holds ready low two cycles running, so the FIFO cannot overflow.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = !ready ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got %h, expected nothing", name, act);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid8 && ready) begin
                if (exp8.size() == 0) report_unexpected("word8", {31'b0, sof8, data8});
                else begin
                    e8 = exp8.pop_front();
                    check_output("word8", {31'b0, sof8, data8}, {31'b0, e8});
                end
            end
            if (valid16 && ready) begin
                if (exp16.size() == 0) report_unexpected("word16", {31'b0, sof16, data16});
                else begin
                    e16 = exp16.pop_front();
                    check_output("word16", {31'b0, sof16, data16}, {31'b0, e16});
                end
            end
            if (done8) begin
                if (exp_done8.size() == 0) report_unexpected("done8", 64'(lines8));
                else begin
                    d8 = exp_done8.pop_front();
                    check_output("done8_lines", 64'(lines8), 64'(d8));
                end
            end
            if (done16) begin
                if (exp_done16.size() == 0) report_unexpected("done16", 64'(lines16));
                else begin
                    d16 = exp_done16.pop_front();
                    check_output("done16_lines", 64'(lines16), 64'(d16));
                end
            end
        end
    end

    // kind: 0 random data and random line length, 1 value = column, 2 value = running count + 1,
    // 3 values 0xAAAA, 0xBBBB, 0xCCCC ...
    task automatic build_frame(input int nl, input int ppl, input int kind);
        int seq = 0;
        fr_line.delete();
        fr_col.delete();
        fr_val.delete();
        line_len.delete();
        fr_lines = nl;
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (kind == 0) ? int'($urandom_range(1, ppl)) : ppl;
            line_len.push_back(len);
            for (int c = 0; c < len; c++) begin
                fr_line.push_back(l);
                fr_col.push_back(c);
                case (kind)
                    0:       fr_val.push_back(16'($urandom));
                    1:       fr_val.push_back(16'(c));
                    2:       fr_val.push_back(16'(seq + 1));
                    default: fr_val.push_back(16'(32'hAAAA + seq * 32'h1111));
                endcase
                seq++;
            end
        end
    endtask

    // Frame-level model: filter by decimation, fill lanes in order, flush the tail, mark the
    // first word; with ready held low only DEPTH words fit and the frame is then lost.
    task automatic model_push(input int lanes, input int mask, input bit hold);
        logic [32:0] wl[$];
        logic [31:0] w;
        int          k;
        bit          lost;
        w = '0;
        k = 0;
        for (int i = 0; i < fr_val.size(); i++) begin
            if (((fr_line[i] & mask) == 0) && ((fr_col[i] & mask) == 0)) begin
                if (lanes == 4) w[8*k +: 8] = fr_val[i][7:0];
                else            w[16*k +: 16] = fr_val[i];
                k++;
                if (k == lanes) begin
                    wl.push_back({1'b0, w});
                    w = '0;
                    k = 0;
                end
            end
        end
        if (k != 0) wl.push_back({1'b0, w});
        if (wl.size() > 0) wl[0][32] = 1'b1;
        lost = hold && (wl.size() > DEPTH);
        for (int i = 0; i < wl.size(); i++) begin
            if (!lost || i < DEPTH) begin
                if (lanes == 4) exp8.push_back(wl[i]);
                else            exp16.push_back(wl[i]);
            end
        end
        if (!lost) begin
            if (lanes == 4) begin
                exp_done8.push_back(fr_lines);
                last_lines8 = fr_lines;
            end else begin
                exp_done16.push_back(fr_lines);
                last_lines16 = fr_lines;
            end
        end
    endtask

    task automatic check_reset_state();
        check_output("rst_valid8", 64'(valid8), 64'd0);
        check_output("rst_valid16", 64'(valid16), 64'd0);
        check_output("rst_data8", 64'(data8), 64'd0);
        check_output("rst_data16", 64'(data16), 64'd0);
        check_output("rst_sof8", 64'(sof8), 64'd0);
        check_output("rst_sof16", 64'(sof16), 64'd0);
        check_output("rst_done8", 64'(done8), 64'd0);
        check_output("rst_done16", 64'(done16), 64'd0);
        check_output("rst_lines8", 64'(lines8), 64'd0);
        check_output("rst_lines16", 64'(lines16), 64'd0);
        check_output("rst_ovf8", 64'(ovf8), 64'd0);
        check_output("rst_ovf16", 64'(ovf16), 64'd0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step(2);
        check_reset_state();
        rst = 1'b0;
        last_lines8 = 0;
        last_lines16 = 0;
    endtask

    task automatic drive_frame(input bit en_val, input bit drop_en, input int rst_at);
        int p = 0;
        en = en_val;
        vsync = 1'b1;
        hsync = 1'b0;
        step(3);
        for (int l = 0; l < fr_lines; l++) begin
            for (int c = 0; c < line_len[l]; c++) begin
                if (p == rst_at) reset_pulse();
                hsync = 1'b1;
                cam_data = fr_val[p];
                step(1);
                p++;
            end
            hsync = 1'b0;
            cam_data = '0;
            step(1 + int'($urandom_range(0, 2)));
            if (drop_en) en = 1'b0;
        end
        step(2);
        vsync = 1'b0;
        step(8);
        en = 1'b1;
    endtask

    task automatic apply_stimulus(input int nl, input int ppl, input int kind, input int dec,
                                  input bit en_val, input bit drop_en, input bit hold, input int rst_at);
        int mask;
        build_frame(nl, ppl, kind);
        decim = 2'(dec);
        mask = (dec == 0) ? 0 : (dec == 1) ? 1 : 3;
        if (en_val && rst_at < 0) begin
            model_push(4, mask, hold);
            model_push(2, mask, hold);
        end
        drive_frame(en_val, drop_en, rst_at);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp8.size() + exp16.size() + exp_done8.size() + exp_done16.size()) != 0 && n < 3000) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("[TB] FAIL drain: pending %0d/%0d words %0d/%0d pulses, expected 0",
                     exp8.size(), exp16.size(), exp_done8.size(), exp_done16.size());
            exp8.delete();
            exp16.delete();
            exp_done8.delete();
            exp_done16.delete();
        end
    endtask

    initial begin
        step(3);
        check_reset_state();
        rst = 1'b0;
        step(2);
        ready_mode = 1;

        $display("[TB] 8-pixel line, no decimation");
        apply_stimulus(1, 8, 2, 0, 1'b1, 1'b0, 1'b0, -1);
        wait_drain();
        check_output("lines8_single", 64'(lines8), 64'd1);

        $display("[TB] three-pixel flush");
        apply_stimulus(1, 3, 3, 0, 1'b1, 1'b0, 1'b0, -1);
        wait_drain();

        $display("[TB] 4:1 decimation, 4 x 16");
        apply_stimulus(4, 16, 1, 2, 1'b1, 1'b0, 1'b0, -1);
        wait_drain();
        check_output("lines8_decim", 64'(lines8), 64'd4);
        check_output("lines16_decim", 64'(lines16), 64'd4);

        $display("[TB] enable low at frame start, then dropped mid-frame");
        apply_stimulus(2, 6, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        apply_stimulus(3, 7, 0, 1, 1'b1, 1'b1, 1'b0, -1);
        wait_drain();

        $display("[TB] overflow under backpressure");
        ready_mode = 0;
        step(2);
        apply_stimulus(1, 24, 2, 0, 1'b1, 1'b0, 1'b1, -1);
        check_output("ovf8_set", 64'(ovf8), 64'd1);
        check_output("ovf16_set", 64'(ovf16), 64'd1);
        check_output("lines8_kept", 64'(lines8), 64'(last_lines8));
        check_output("lines16_kept", 64'(lines16), 64'(last_lines16));
        ready_mode = 1;
        wait_drain();
        apply_stimulus(2, 5, 0, 0, 1'b1, 1'b0, 1'b0, -1);
        wait_drain();
        check_output("ovf8_sticky", 64'(ovf8), 64'd1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_output("ovf8_clr", 64'(ovf8), 64'd0);
        check_output("ovf16_clr", 64'(ovf16), 64'd0);

        $display("[TB] reset mid-line");
        ready_mode = 0;
        step(2);
        apply_stimulus(1, 6, 2, 0, 1'b1, 1'b0, 1'b0, 3);
        ready_mode = 1;
        step(4);
        apply_stimulus(1, 8, 2, 0, 1'b1, 1'b0, 1'b0, -1);
        wait_drain();

        $display("[TB] random frames");
        ready_mode = 2;
        for (int f = 0; f < 20; f++) begin
            apply_stimulus(int'($urandom_range(1, 5)), 12, 0, int'($urandom_range(0, 3)),
                           1'b1, 1'b0, 1'b0, -1);
        end
        wait_drain();
        check_output("ovf8_random", 64'(ovf8), 64'd0);
        check_output("ovf16_random", 64'(ovf16), 64'd0);
        check_output("lines8_random", 64'(lines8), 64'(last_lines8));
        check_output("lines16_random", 64'(lines16), 64'(last_lines16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
